// File: rtl/display_7seg_pkg.sv
// Shared constants for the 4-digit 7-segment scanner: digit count, scan slot
// encoding and active-high segment patterns in {g,f,e,d,c,b,a} order.
package display_7seg_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } digit_e;

    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    // Select nibble k (k=0 is the rightmost digit) from a packed BCD word.
    function automatic logic [3:0] bcd_nibble(input logic [15:0] v, input logic [1:0] k);
        logic [3:0] n;
        case (k)
            2'd0:    n = v[3:0];
            2'd1:    n = v[7:4];
            2'd2:    n = v[11:8];
            default: n = v[15:12];
        endcase
        return n;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational nibble-to-segment decoder; active-high output, codes 10-15 show a dash.
module bcd_to_7seg
    import display_7seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_DASH;
        case (nibble)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_7seg_scan.sv
// Time-multiplexed 4-digit 7-segment driver with frame-coherent BCD snapshot,
// leading-zero blanking and registered, polarity-selectable outputs.
module display_7seg_scan
    import display_7seg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,  // clk cycles per digit slot, must be >= 2
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bcd,
    input  logic [3:0]  dp_mask,
    input  logic        blank_lz,
    input  logic        enable,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int          CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    localparam logic [3:0] AN_OFF   = {4{ACTIVE_LOW}};
    localparam logic [6:0] SEG_IDLE = {7{ACTIVE_LOW}};
    localparam logic       DP_IDLE  = ACTIVE_LOW;

    logic [CW-1:0] cnt;
    logic          slot_tick;
    digit_e        state, state_nx;
    logic [1:0]    idx;

    logic [15:0] shadow_bcd;
    logic [3:0]  shadow_dp;

    logic [3:0] cur_nibble;
    logic [6:0] cur_pattern;
    logic [3:0] lz_blank;
    logic [3:0] an_h;
    logic [6:0] seg_h;
    logic       dp_h;

    // Slot prescaler
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (slot_tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign slot_tick = (cnt == CNT_MAX);

    // Scan FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= DIG0;
        else
            state <= state_nx;
    end

    // Scan FSM: next state, one digit per slot
    always_comb begin
        state_nx = state;
        if (slot_tick) begin
            case (state)
                DIG0:    state_nx = DIG1;
                DIG1:    state_nx = DIG2;
                DIG2:    state_nx = DIG3;
                default: state_nx = DIG0;
            endcase
        end
    end

    assign idx = state;

    // Snapshot at the frame wrap so the CPU can update bcd without tearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_bcd <= '0;
            shadow_dp  <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            if (slot_tick && state == DIG3) begin
                shadow_bcd <= bcd;
                shadow_dp  <= dp_mask;
                frame_tick <= 1'b1;
            end
        end
    end

    assign cur_nibble = bcd_nibble(shadow_bcd, idx);

    bcd_to_7seg u_dec (
        .nibble  (cur_nibble),
        .pattern (cur_pattern)
    );

    // Digit k is a leading zero when it and every digit to its left are zero.
    always_comb begin
        lz_blank    = 4'b0000;
        lz_blank[3] = (shadow_bcd[15:12] == 4'd0);
        lz_blank[2] = lz_blank[3] && (shadow_bcd[11:8] == 4'd0);
        lz_blank[1] = lz_blank[2] && (shadow_bcd[7:4] == 4'd0);
    end

    // Scan FSM: output decode, active-high before the polarity register
    always_comb begin
        an_h  = enable ? (4'b0001 << idx) : 4'b0000;
        seg_h = (blank_lz && lz_blank[idx]) ? SEG_OFF : cur_pattern;
        dp_h  = shadow_dp[idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= AN_OFF;
            seg <= SEG_IDLE;
            dp  <= DP_IDLE;
        end else begin
            an  <= an_h  ^ AN_OFF;
            seg <= seg_h ^ SEG_IDLE;
            dp  <= dp_h  ^ DP_IDLE;
        end
    end

endmodule
